perceptron_trainer: RTL

- Training sequencer that drives the perceptron core's sample interface and consumes its result.
- Holds a small bank of labelled samples, loaded through a write port.
- Presents the samples to the perceptron in order, waits a fixed settle time, then samples the perceptron result and counts misclassifications per epoch.
- Repeats epochs until an epoch has zero errors (converged) or MAX_EPOCHS is reached; sits between host/config logic and the perceptron instance.

---
 rtl/perceptron_pkg.sv | 19 +
 rtl/trainer_sample_bank.sv | 27 ++
 rtl/perceptron_trainer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron core and its training sequencer.
package perceptron_pkg;

  localparam int unsigned N_IN_DEFAULT = 7;

  // Bit positions within the perceptron's 2-bit result bus.
  localparam int unsigned RES_CLASS    = 0;
  localparam int unsigned RES_MISMATCH = 1;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StWait,
    StSample,
    StEpochEnd,
    StDone
  } state_t;

endpackage

// File: rtl/trainer_sample_bank.sv
// Labelled sample store: synchronous write, combinational read, entries are {vec, label}.
module trainer_sample_bank
  import perceptron_pkg::*;
#(
  parameter int unsigned N_IN      = N_IN_DEFAULT,
  parameter int unsigned N_SAMPLES = 8,
  localparam int unsigned AW       = $clog2(N_SAMPLES)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N_IN:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [N_IN:0] rdata
);

  logic [N_IN:0] mem [N_SAMPLES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/perceptron_trainer.sv
// Epoch sequencer: presents banked samples to the perceptron, counts mismatches,
// and stops on a clean epoch or after MAX_EPOCHS.
module perceptron_trainer
  import perceptron_pkg::*;
#(
  parameter int unsigned N_IN       = N_IN_DEFAULT,
  parameter int unsigned N_SAMPLES  = 8,
  parameter int unsigned MAX_EPOCHS = 15,
  parameter int unsigned SETTLE     = 2,
  localparam int unsigned AW        = $clog2(N_SAMPLES),
  localparam int unsigned SW        = $clog2(SETTLE + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_we,
  input  logic [AW-1:0]   load_addr,
  input  logic [N_IN-1:0] load_vec,
  input  logic            load_label,
  input  logic            start,
  input  logic [7:0]      threshold_cfg,
  output logic [N_IN-1:0] pc_in,
  output logic [7:0]      pc_threshold,
  output logic            pc_exp_res,
  input  logic [1:0]      pc_result,
  output logic            busy,
  output logic            done,
  output logic            converged,
  output logic [3:0]      epoch_cnt,
  output logic [3:0]      err_cnt
);

  state_t        state;
  logic [AW-1:0] idx;
  logic [SW-1:0] settle_cnt;
  logic [N_IN:0] bank_rd;
  logic          bank_we;
  logic          unused_class;

  assign unused_class = pc_result[RES_CLASS];
  assign bank_we      = load_we && ((state == StIdle) || (state == StDone));

  trainer_sample_bank #(
    .N_IN      (N_IN),
    .N_SAMPLES (N_SAMPLES)
  ) u_bank (
    .clk   (clk),
    .we    (bank_we),
    .waddr (load_addr),
    .wdata ({load_vec, load_label}),
    .raddr (idx),
    .rdata (bank_rd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= StIdle;
      pc_in        <= '0;
      pc_exp_res   <= 1'b0;
      pc_threshold <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      converged    <= 1'b0;
      epoch_cnt    <= '0;
      err_cnt      <= '0;
      idx          <= '0;
      settle_cnt   <= '0;
    end else begin
      unique case (state)
        StIdle, StDone: begin
          if (start) begin
            state        <= StDrive;
            idx          <= '0;
            epoch_cnt    <= '0;
            err_cnt      <= '0;
            converged    <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b1;
            pc_threshold <= threshold_cfg;
          end
        end
        StDrive: begin
          pc_in      <= bank_rd[N_IN:1];
          pc_exp_res <= bank_rd[0];
          settle_cnt <= SW'(SETTLE);
          // With SETTLE=1 the DRIVE edge alone covers the settle time.
          state      <= (SETTLE <= 1) ? StSample : StWait;
        end
        StWait: begin
          settle_cnt <= settle_cnt - 1'b1;
          if (settle_cnt <= SW'(2)) begin
            state <= StSample;
          end
        end
        StSample: begin
          if (pc_result[RES_MISMATCH] && (err_cnt != 4'hF)) begin
            err_cnt <= err_cnt + 4'd1;
          end
          if (idx == AW'(N_SAMPLES - 1)) begin
            state <= StEpochEnd;
          end else begin
            idx   <= idx + 1'b1;
            state <= StDrive;
          end
        end
        StEpochEnd: begin
          epoch_cnt <= epoch_cnt + 4'd1;
          if (err_cnt == 4'd0) begin
            converged <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= StDone;
          end else if (epoch_cnt == 4'(MAX_EPOCHS - 1)) begin
            converged <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= StDone;
          end else begin
            err_cnt <= '0;
            idx     <= '0;
            state   <= StDrive;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
